x_dmx16: RTL and testbench

Registered 16-way event distributor: the expanding counterpart of the 16-input OR-reduce cells. It accepts single events on one valid/ready input and steers each to one of 16 one-hot lanes, either round-robin or by explicit address. Each lane holds its pending flag until that lane's ACK arrives. A registered OR of all lanes is exported as BUSY. It sits between a single event source and 16 consumer lanes in the simprim-level netlists.

---
 rtl/x_dmx16_pkg.sv | 30 +++
 rtl/x_dmx16_if.sv | 25 ++
 rtl/x_dmx16_pe.sv | 17 +
 rtl/x_dmx16.sv | 74 +++++++
 tb/tb_x_dmx16.sv | 181 ++++++++++++++++++
 5 files changed

// File: rtl/x_dmx16_pkg.sv
// Shared constants and the cyclic free-lane search for the x_dmx16 event distributor.
package x_dmx16_pkg;

  localparam int LANES = 16;
  localparam int PTR_W = 4;
  localparam int CNT_W = 5;

  typedef struct packed {
    logic             found;
    logic [PTR_W-1:0] idx;
  } free_t;

  // First non-pending lane visiting ptr, ptr+1, ... with 4-bit wraparound.
  function automatic free_t next_free(input logic [PTR_W-1:0] ptr,
                                      input logic [LANES-1:0] pending);
    free_t            r;
    logic [PTR_W-1:0] cand;
    r.found = 1'b0;
    r.idx   = ptr;
    for (int i = 0; i < LANES; i++) begin
      cand = ptr + PTR_W'(i);
      if (!r.found && !pending[cand]) begin
        r.found = 1'b1;
        r.idx   = cand;
      end
    end
    return r;
  endfunction

endpackage

// File: rtl/x_dmx16_if.sv
// Event-side and lane-side signals of x_dmx16.
// Handshake: an event transfers on a rising CLK edge where I=1 and RDY=1; RDY never depends on I or ACK.
interface x_dmx16_if;
  import x_dmx16_pkg::*;

  logic             I;
  logic             RDY;
  logic             DIRECT;
  logic [PTR_W-1:0] ADDR;
  logic [LANES-1:0] ACK;
  logic [LANES-1:0] O;
  logic             BUSY;
  logic [CNT_W-1:0] CNT;
  logic [PTR_W-1:0] PTR;

  modport master (
    output I, DIRECT, ADDR, ACK,
    input  RDY, O, BUSY, CNT, PTR
  );

  modport slave (
    input  I, DIRECT, ADDR, ACK,
    output RDY, O, BUSY, CNT, PTR
  );
endinterface

// File: rtl/x_dmx16_pe.sv
// 16-bit cyclic priority encoder: finds the first free lane starting at ptr.
module x_dmx16_pe
  import x_dmx16_pkg::*;
(
  input  logic [PTR_W-1:0] ptr,
  input  logic [LANES-1:0] pending,
  output logic [PTR_W-1:0] idx,
  output logic             found
);

  free_t res;

  assign res   = next_free(ptr, pending);
  assign idx   = res.idx;
  assign found = res.found;

endmodule

// File: rtl/x_dmx16.sv
// Registered 16-way event distributor with round-robin or direct lane steering.
// Define X_DMX16_SKIP_EN to let round-robin skip pending lanes instead of stalling.
module x_dmx16
  import x_dmx16_pkg::*;
#(
  parameter logic [PTR_W-1:0] INIT_PTR = 4'h0
) (
  input  logic        CLK,
  input  logic        RST,
  x_dmx16_if.slave    bus
);

  logic [LANES-1:0] o_q;
  logic [PTR_W-1:0] ptr_q;
  logic [CNT_W-1:0] cnt_q;
  logic             busy_q;

  logic [PTR_W-1:0] rr_lane;
  logic             rr_rdy;
  logic [PTR_W-1:0] tgt;
  logic             rdy;
  logic             accept;
  logic [LANES-1:0] ack_eff;
  logic [LANES-1:0] o_next;

`ifdef X_DMX16_SKIP_EN
  logic [PTR_W-1:0] skip_idx;
  logic             skip_found;

  x_dmx16_pe u_pe (
    .ptr     (ptr_q),
    .pending (o_q),
    .idx     (skip_idx),
    .found   (skip_found)
  );

  assign rr_lane = skip_idx;
  assign rr_rdy  = skip_found;
`else
  assign rr_lane = ptr_q;
  assign rr_rdy  = ~o_q[ptr_q];
`endif

  always_comb begin
    tgt     = bus.DIRECT ? bus.ADDR : rr_lane;
    rdy     = bus.DIRECT ? ~o_q[bus.ADDR] : rr_rdy;
    accept  = bus.I & rdy;
    // Only acks on pending lanes count; a blocked target cannot be acked and re-set in one edge.
    ack_eff = bus.ACK & o_q;
    o_next  = o_q & ~ack_eff;
    if (accept) o_next = o_next | (LANES'(1) << tgt);
  end

  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      o_q    <= '0;
      ptr_q  <= INIT_PTR;
      cnt_q  <= '0;
      busy_q <= 1'b0;
    end else begin
      o_q    <= o_next;
      cnt_q  <= CNT_W'($countones(o_next));
      busy_q <= |o_next;
      if (accept && !bus.DIRECT) ptr_q <= tgt + PTR_W'(1);
    end
  end

  assign bus.RDY  = rdy;
  assign bus.O    = o_q;
  assign bus.BUSY = busy_q;
  assign bus.CNT  = cnt_q;
  assign bus.PTR  = ptr_q;

endmodule

// File: tb/tb_x_dmx16.sv
// Directed self-checking bench for x_dmx16 (INIT_PTR = 4'hE).
`timescale 1ps/1ps
module tb_x_dmx16;
  import x_dmx16_pkg::*;

  logic CLK;
  logic RST;
  int   tests_run;
  int   tests_failed;

  x_dmx16_if bus ();

  x_dmx16 #(.INIT_PTR(4'hE)) dut (
    .CLK (CLK),
    .RST (RST),
    .bus (bus)
  );

  // clock / reset
  initial CLK = 1'b0;
  always #5 CLK = ~CLK;

  task automatic step();
    @(posedge CLK);
    #1;
  endtask

  task automatic test_reset();
    RST = 1'b1;
    bus.I = 1'b0; bus.DIRECT = 1'b0; bus.ADDR = '0; bus.ACK = '0;
    repeat (3) @(posedge CLK);
    @(negedge CLK);
    RST = 1'b0;
    #1;
    tests_run++; if (bus.O !== 16'h0000) begin tests_failed++; $display("FAIL reset_o: got %h want %h", bus.O, 16'h0000); end
    tests_run++; if (bus.BUSY !== 1'b0) begin tests_failed++; $display("FAIL reset_busy: got %b want 0", bus.BUSY); end
    tests_run++; if (bus.CNT !== 5'd0) begin tests_failed++; $display("FAIL reset_cnt: got %0d want 0", bus.CNT); end
    tests_run++; if (bus.PTR !== 4'hE) begin tests_failed++; $display("FAIL reset_ptr: got %h want e", bus.PTR); end
    tests_run++; if (bus.RDY !== 1'b1) begin tests_failed++; $display("FAIL reset_rdy: got %b want 1", bus.RDY); end
  endtask

  task automatic test_rr_wrap();
    logic [15:0] exp_o [3];
    exp_o[0] = 16'h4000; exp_o[1] = 16'hC000; exp_o[2] = 16'hC001;
    bus.DIRECT = 1'b0; bus.I = 1'b1;
    for (int i = 0; i < 3; i++) begin
      step();
      tests_run++; if (bus.O !== exp_o[i]) begin tests_failed++; $display("FAIL rr_o%0d: got %h want %h", i, bus.O, exp_o[i]); end
    end
    bus.I = 1'b0;
    tests_run++; if (bus.PTR !== 4'h1) begin tests_failed++; $display("FAIL rr_ptr: got %h want 1", bus.PTR); end
    tests_run++; if (bus.CNT !== 5'd3) begin tests_failed++; $display("FAIL rr_cnt: got %0d want 3", bus.CNT); end
    tests_run++; if (bus.BUSY !== 1'b1) begin tests_failed++; $display("FAIL rr_busy: got %b want 1", bus.BUSY); end
  endtask

  task automatic test_direct();
    bus.DIRECT = 1'b1; bus.ADDR = 4'd5; bus.I = 1'b1;
    step();
    tests_run++; if (bus.O !== 16'hC021) begin tests_failed++; $display("FAIL dir_o: got %h want c021", bus.O); end
    tests_run++; if (bus.PTR !== 4'h1) begin tests_failed++; $display("FAIL dir_ptr: got %h want 1", bus.PTR); end
    tests_run++; if (bus.CNT !== 5'd4) begin tests_failed++; $display("FAIL dir_cnt: got %0d want 4", bus.CNT); end
    #1;
    tests_run++; if (bus.RDY !== 1'b0) begin tests_failed++; $display("FAIL dir_rdy_busy: got %b want 0", bus.RDY); end
    step();
    tests_run++; if (bus.O !== 16'hC021) begin tests_failed++; $display("FAIL dir_o_hold: got %h want c021", bus.O); end
    bus.I = 1'b0; bus.ACK = 16'h0020;
    step();
    bus.ACK = '0;
    tests_run++; if (bus.O !== 16'hC001) begin tests_failed++; $display("FAIL dir_ack_o: got %h want c001", bus.O); end
    #1;
    tests_run++; if (bus.RDY !== 1'b1) begin tests_failed++; $display("FAIL dir_ack_rdy: got %b want 1", bus.RDY); end
  endtask

  task automatic test_multi_ack();
    // Lane 8 is not pending, so its ack bit must be ignored.
    bus.ACK = 16'hC100;
    step();
    bus.ACK = '0;
    tests_run++; if (bus.O !== 16'h0001) begin tests_failed++; $display("FAIL mack_o: got %h want 0001", bus.O); end
    tests_run++; if (bus.CNT !== 5'd1) begin tests_failed++; $display("FAIL mack_cnt: got %0d want 1", bus.CNT); end
  endtask

  task automatic test_simultaneous();
    bus.DIRECT = 1'b0; bus.I = 1'b1; bus.ACK = 16'h0001;
    step();
    bus.I = 1'b0; bus.ACK = '0;
    tests_run++; if (bus.O !== 16'h0002) begin tests_failed++; $display("FAIL sim_o: got %h want 0002", bus.O); end
    tests_run++; if (bus.CNT !== 5'd1) begin tests_failed++; $display("FAIL sim_cnt: got %0d want 1", bus.CNT); end
    tests_run++; if (bus.BUSY !== 1'b1) begin tests_failed++; $display("FAIL sim_busy: got %b want 1", bus.BUSY); end
    tests_run++; if (bus.PTR !== 4'h2) begin tests_failed++; $display("FAIL sim_ptr: got %h want 2", bus.PTR); end
  endtask

  task automatic test_accept_and_ack();
    bus.DIRECT = 1'b1; bus.ADDR = 4'd2; bus.I = 1'b1; bus.ACK = 16'h0002;
    step();
    bus.I = 1'b0; bus.ACK = '0;
    tests_run++; if (bus.O !== 16'h0004) begin tests_failed++; $display("FAIL aa_o: got %h want 0004", bus.O); end
    tests_run++; if (bus.CNT !== 5'd1) begin tests_failed++; $display("FAIL aa_cnt: got %0d want 1", bus.CNT); end
    tests_run++; if (bus.PTR !== 4'h2) begin tests_failed++; $display("FAIL aa_ptr: got %h want 2", bus.PTR); end
  endtask

  task automatic test_stall_skip();
    logic             exp_rdy;
    logic [15:0]      exp_o;
    logic [PTR_W-1:0] exp_ptr;
`ifdef X_DMX16_SKIP_EN
    exp_rdy = 1'b1; exp_o = 16'h000C; exp_ptr = 4'h4;
`else
    exp_rdy = 1'b0; exp_o = 16'h0004; exp_ptr = 4'h2;
`endif
    bus.DIRECT = 1'b0; bus.I = 1'b1;
    #1;
    tests_run++; if (bus.RDY !== exp_rdy) begin tests_failed++; $display("FAIL ss_rdy: got %b want %b", bus.RDY, exp_rdy); end
    step();
    bus.I = 1'b0;
    tests_run++; if (bus.O !== exp_o) begin tests_failed++; $display("FAIL ss_o: got %h want %h", bus.O, exp_o); end
    tests_run++; if (bus.PTR !== exp_ptr) begin tests_failed++; $display("FAIL ss_ptr: got %h want %h", bus.PTR, exp_ptr); end
  endtask

  task automatic test_reset_mid();
    logic [3:0] lanes [6];
    lanes[0] = 4'd0; lanes[1] = 4'd1; lanes[2] = 4'd4;
    lanes[3] = 4'd5; lanes[4] = 4'd6; lanes[5] = 4'd7;
    bus.ACK = 16'hFFFF;
    step();
    bus.ACK = '0; bus.DIRECT = 1'b1; bus.I = 1'b1;
    for (int i = 0; i < 6; i++) begin
      bus.ADDR = lanes[i];
      step();
    end
    tests_run++; if (bus.O !== 16'h00F3) begin tests_failed++; $display("FAIL rm_pre_o: got %h want 00f3", bus.O); end
    // Keep the event pending while reset hits, mid-cycle.
    #2;
    RST = 1'b1;
    #1;
    tests_run++; if (bus.O !== 16'h0000) begin tests_failed++; $display("FAIL rm_o: got %h want 0000", bus.O); end
    tests_run++; if (bus.BUSY !== 1'b0) begin tests_failed++; $display("FAIL rm_busy: got %b want 0", bus.BUSY); end
    tests_run++; if (bus.CNT !== 5'd0) begin tests_failed++; $display("FAIL rm_cnt: got %0d want 0", bus.CNT); end
    tests_run++; if (bus.PTR !== 4'hE) begin tests_failed++; $display("FAIL rm_ptr: got %h want e", bus.PTR); end
    bus.I = 1'b0; bus.DIRECT = 1'b0;
    @(negedge CLK);
    RST = 1'b0;
    #1;
  endtask

  task automatic test_full();
    bus.DIRECT = 1'b0; bus.I = 1'b1;
    repeat (16) step();
    bus.I = 1'b0;
    tests_run++; if (bus.O !== 16'hFFFF) begin tests_failed++; $display("FAIL full_o: got %h want ffff", bus.O); end
    tests_run++; if (bus.CNT !== 5'd16) begin tests_failed++; $display("FAIL full_cnt: got %0d want 16", bus.CNT); end
    tests_run++; if (bus.PTR !== 4'hE) begin tests_failed++; $display("FAIL full_ptr: got %h want e", bus.PTR); end
    #1;
    tests_run++; if (bus.RDY !== 1'b0) begin tests_failed++; $display("FAIL full_rdy: got %b want 0", bus.RDY); end
    bus.ACK = 16'hFFFF;
    step();
    bus.ACK = '0;
    tests_run++; if (bus.O !== 16'h0000) begin tests_failed++; $display("FAIL drain_o: got %h want 0000", bus.O); end
    tests_run++; if (bus.CNT !== 5'd0) begin tests_failed++; $display("FAIL drain_cnt: got %0d want 0", bus.CNT); end
    tests_run++; if (bus.BUSY !== 1'b0) begin tests_failed++; $display("FAIL drain_busy: got %b want 0", bus.BUSY); end
    #1;
    tests_run++; if (bus.RDY !== 1'b1) begin tests_failed++; $display("FAIL drain_rdy: got %b want 1", bus.RDY); end
  endtask

  initial begin
    tests_run    = 0;
    tests_failed = 0;
    test_reset();
    test_rr_wrap();
    test_direct();
    test_multi_ack();
    test_simultaneous();
    test_accept_and_ack();
    test_stall_skip();
    test_reset_mid();
    test_full();
    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

endmodule
